// File: rtl/bmu_wb_pkg.sv
// Shared defaults and the writeback entry layout for the BMU writeback buffer.
package bmu_wb_pkg;

  localparam int BMU_WB_DEPTH = 4;
  localparam int BMU_WB_RD_W  = 5;
  localparam int BMU_WB_CNT_W = 16;

  typedef struct packed {
    logic [BMU_WB_RD_W-1:0] rd;
    logic [31:0]            data;
    logic                   error;
  } bmu_wb_entry_t;

endpackage

// File: rtl/bmu_wb_fifo.sv
// Small synchronous FIFO with a combinational head view, occupancy count and
// a synchronous flush that empties it in one edge.
module bmu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_C = DEPTH[PW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; only entries behind a valid count are ever read out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bmu_wb_buffer.sv
// Writeback buffer behind the BMU: aligns issued tags with the registered BMU
// result, queues them for the register file and returns issue credit.
module bmu_wb_buffer
  import bmu_wb_pkg::*;
#(
  parameter int DEPTH = BMU_WB_DEPTH,
  parameter int RD_W  = BMU_WB_RD_W,
  parameter int CNT_W = BMU_WB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             issue_valid,
  input  logic [RD_W-1:0]  issue_rd,
  output logic             issue_ready,
  input  logic [31:0]      bmu_result,
  input  logic             bmu_error,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RD_W-1:0]  wb_rd,
  output logic [31:0]      wb_data,
  output logic             wb_error,
  output logic [CNT_W-1:0] err_count,
  output logic             ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = RD_W + 33;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic            s1_valid;
  logic [RD_W-1:0] s1_rd;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic [CW:0]     credit_used;
  logic            issue_accept;
  logic            illegal_issue;
  logic            push;
  logic            pop;

  // The op sitting in s1 already owns a FIFO slot, so it counts against credit.
  assign credit_used   = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign issue_ready   = (credit_used < DEPTH_C);
  assign illegal_issue = issue_valid && !issue_ready;
  assign issue_accept  = issue_valid && issue_ready && !flush;
  assign push          = s1_valid && !flush;
  assign pop           = wb_valid && wb_ready;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid  <= 1'b0;
      s1_rd     <= '0;
      ovf       <= 1'b0;
      err_count <= '0;
    end else begin
      s1_valid <= issue_accept;
      if (issue_accept) s1_rd <= issue_rd;
      if (illegal_issue) ovf <= 1'b1;
      if (push && bmu_error && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end

  bmu_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .flush (flush),
    .push  (push),
    .din   ({s1_rd, bmu_result, bmu_error}),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign wb_valid = (count != '0);
  // Masking keeps the head fields at zero whenever nothing is buffered.
  assign {wb_rd, wb_data, wb_error} = wb_valid ? head : '0;

endmodule

// File: tb/tb_bmu_wb_buffer.sv
// Self-checking bench for bmu_wb_buffer: directed vector table, flush and
// mid-stream reset sequences, then random traffic against a queue model.
module tb_bmu_wb_buffer;
  import bmu_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int RD_W  = 5;
  localparam int CNT_W = 16;
  localparam int NVEC  = 15;

  logic             clk = 1'b0;
  logic             rst_l;
  logic             issue_valid;
  logic [RD_W-1:0]  issue_rd;
  logic             issue_ready;
  logic [31:0]      bmu_result;
  logic             bmu_error;
  logic             flush;
  logic             wb_valid;
  logic             wb_ready;
  logic [RD_W-1:0]  wb_rd;
  logic [31:0]      wb_data;
  logic             wb_error;
  logic [CNT_W-1:0] err_count;
  logic             ovf;

  logic [31:0] op_a;
  logic [31:0] op_b;

  int n_checks = 0;
  int n_pass   = 0;

  bmu_wb_buffer #(.DEPTH(DEPTH), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .bmu_result  (bmu_result),
    .bmu_error   (bmu_error),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_error    (wb_error),
    .err_count   (err_count),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  // Signed add overflow, standing in for the BMU error flag.
  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  // Stand-in BMU: one-cycle registered add.
  always @(posedge clk) begin
    bmu_result <= op_a + op_b;
    bmu_error  <= add_ovf(op_a, op_b);
  end

  // Reference model: a queue of buffered entries plus one op in flight.
  bmu_wb_entry_t m_q[$];
  bit            m_s1;
  bmu_wb_entry_t m_s1e;
  int            m_err;
  bit            m_ovf;

  function automatic bit model_ready();
    return (m_q.size() + int'(m_s1)) < DEPTH;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_s1  = 1'b0;
    m_err = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic iv, input logic [4:0] rd, input logic [31:0] a,
                            input logic [31:0] b, input logic wr, input logic fl);
    bit rdy;
    rdy = model_ready();
    if (iv && !rdy) m_ovf = 1'b1;
    if (fl) begin
      m_q.delete();
      m_s1 = 1'b0;
    end else begin
      if (wr && m_q.size() > 0) void'(m_q.pop_front());
      if (m_s1) begin
        m_q.push_back(m_s1e);
        if (m_s1e.error && m_err < 65535) m_err++;
      end
      m_s1        = iv && rdy;
      m_s1e.rd    = rd;
      m_s1e.data  = a + b;
      m_s1e.error = add_ovf(a, b);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic compare_model();
    check("model.wb_valid", wb_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("model.wb_rd", wb_rd, m_q[0].rd);
      check("model.wb_data", wb_data, m_q[0].data);
      check("model.wb_error", wb_error, m_q[0].error);
    end
    check("model.issue_ready", issue_ready, model_ready());
    check("model.err_count", err_count, m_err);
    check("model.ovf", ovf, m_ovf);
  endtask

  task automatic cycle(input logic iv, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic wr, input logic fl);
    issue_valid = iv;
    issue_rd    = rd;
    op_a        = a;
    op_b        = b;
    wb_ready    = wr;
    flush       = fl;
    if (wb_valid && wr && !fl)
      $display("txn: wb pop rd=%0d data=0x%08h err=%0b", wb_rd, wb_data, wb_error);
    model_step(iv, rd, a, b, wr, fl);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr;
    logic        fl;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_err;
    logic        e_ready;
    int          e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vt[NVEC];

  function automatic vec_t mk(input logic iv, input logic [4:0] rd, input logic [31:0] a,
                              input logic [31:0] b, input logic wr, input logic ev,
                              input logic [4:0] erd, input logic [31:0] ed, input logic ee,
                              input logic erdy, input int ecnt, input logic eovf);
    vec_t v;
    v.iv = iv; v.rd = rd; v.a = a; v.b = b; v.wr = wr; v.fl = 1'b0;
    v.e_valid = ev; v.e_rd = erd; v.e_data = ed; v.e_err = ee;
    v.e_ready = erdy; v.e_cnt = ecnt; v.e_ovf = eovf;
    return v;
  endfunction

  initial begin
    //          iv rd  a             b  wr | valid rd  data          err rdy cnt ovf
    vt[0]  = mk(1, 3,  32'h5,        32'h7, 0,  0, 0,  32'h0,        0,  1,  0,  0);
    vt[1]  = mk(0, 0,  32'h0,        32'h0, 0,  1, 3,  32'hC,        0,  1,  0,  0);
    vt[2]  = mk(1, 9,  32'h7FFFFFFF, 32'h1, 1,  0, 0,  32'h0,        0,  1,  0,  0);
    vt[3]  = mk(0, 0,  32'h0,        32'h0, 0,  1, 9,  32'h80000000, 1,  1,  1,  0);
    vt[4]  = mk(0, 0,  32'h0,        32'h0, 1,  0, 0,  32'h0,        0,  1,  1,  0);
    vt[5]  = mk(1, 10, 32'h10A,      32'h0, 0,  0, 0,  32'h0,        0,  1,  1,  0);
    vt[6]  = mk(1, 11, 32'h10B,      32'h0, 0,  1, 10, 32'h10A,      0,  1,  1,  0);
    vt[7]  = mk(1, 12, 32'h10C,      32'h0, 0,  1, 10, 32'h10A,      0,  1,  1,  0);
    vt[8]  = mk(1, 13, 32'h10D,      32'h0, 0,  1, 10, 32'h10A,      0,  0,  1,  0);
    vt[9]  = mk(0, 0,  32'h0,        32'h0, 0,  1, 10, 32'h10A,      0,  0,  1,  0);
    vt[10] = mk(1, 20, 32'h114,      32'h0, 0,  1, 10, 32'h10A,      0,  0,  1,  1);
    vt[11] = mk(0, 0,  32'h0,        32'h0, 1,  1, 11, 32'h10B,      0,  1,  1,  1);
    vt[12] = mk(0, 0,  32'h0,        32'h0, 1,  1, 12, 32'h10C,      0,  1,  1,  1);
    vt[13] = mk(0, 0,  32'h0,        32'h0, 1,  1, 13, 32'h10D,      0,  1,  1,  1);
    vt[14] = mk(0, 0,  32'h0,        32'h0, 1,  0, 0,  32'h0,        0,  1,  1,  1);

    rst_l = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0; wb_ready = 1'b0;
    op_a = '0; op_b = '0;
    model_reset();
    #12;
    check("reset.wb_valid", wb_valid, 0);
    check("reset.wb_rd", wb_rd, 0);
    check("reset.wb_data", wb_data, 0);
    check("reset.wb_error", wb_error, 0);
    check("reset.err_count", err_count, 0);
    check("reset.ovf", ovf, 0);
    check("reset.issue_ready", issue_ready, 1);
    rst_l = 1'b1;

    // Directed table: single op, overflow op, backpressure, illegal issue, drain.
    for (int i = 0; i < NVEC; i++) begin
      cycle(vt[i].iv, vt[i].rd, vt[i].a, vt[i].b, vt[i].wr, vt[i].fl);
      check($sformatf("vec%0d.wb_valid", i), wb_valid, vt[i].e_valid);
      if (vt[i].e_valid) begin
        check($sformatf("vec%0d.wb_rd", i), wb_rd, vt[i].e_rd);
        check($sformatf("vec%0d.wb_data", i), wb_data, vt[i].e_data);
        check($sformatf("vec%0d.wb_error", i), wb_error, vt[i].e_err);
      end
      check($sformatf("vec%0d.issue_ready", i), issue_ready, vt[i].e_ready);
      check($sformatf("vec%0d.err_count", i), err_count, vt[i].e_cnt);
      check($sformatf("vec%0d.ovf", i), ovf, vt[i].e_ovf);
    end

    // Flush with three buffered entries and an error op still in s1.
    cycle(1, 1, 32'h1,        32'h1,        0, 0);
    cycle(1, 2, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0);
    cycle(1, 3, 32'h3,        32'h0,        0, 0);
    cycle(1, 4, 32'h80000000, 32'h80000000, 0, 0);
    check("flush.pre.wb_rd", wb_rd, 1);
    check("flush.pre.err_count", err_count, 2);
    check("flush.pre.issue_ready", issue_ready, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 1);
    check("flush.wb_valid", wb_valid, 0);
    check("flush.issue_ready", issue_ready, 1);
    check("flush.err_count", err_count, 2);
    check("flush.ovf", ovf, 1);
    cycle(0, 0, 32'h0, 32'h0, 0, 0);
    check("flush.after.wb_valid", wb_valid, 0);
    check("flush.after.err_count", err_count, 2);

    // Asynchronous reset with two entries buffered, then a fresh op.
    cycle(1, 5, 32'h1, 32'h2, 0, 0);
    cycle(1, 6, 32'h2, 32'h2, 0, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 0);
    check("rst.pre.wb_valid", wb_valid, 1);
    rst_l = 1'b0;
    #2;
    check("rst.wb_valid", wb_valid, 0);
    check("rst.wb_rd", wb_rd, 0);
    check("rst.wb_data", wb_data, 0);
    check("rst.err_count", err_count, 0);
    check("rst.ovf", ovf, 0);
    check("rst.issue_ready", issue_ready, 1);
    #1;
    rst_l = 1'b1;
    model_reset();
    cycle(1, 7, 32'h2, 32'h3, 0, 0);
    check("rst.post1.wb_valid", wb_valid, 0);
    cycle(0, 0, 32'h0, 32'h0, 1, 0);
    check("rst.post2.wb_valid", wb_valid, 1);
    check("rst.post2.wb_rd", wb_rd, 7);
    check("rst.post2.wb_data", wb_data, 32'h5);
    check("rst.post2.wb_error", wb_error, 0);
    cycle(0, 0, 32'h0, 32'h0, 1, 0);

    // Random traffic; illegal issues and flushes are kept rare.
    for (int n = 0; n < 600; n++) begin
      logic iv;
      logic [4:0] rd;
      logic [31:0] a;
      logic [31:0] b;
      logic wr;
      logic fl;
      if (model_ready()) iv = ($urandom_range(0, 99) < 70);
      else               iv = ($urandom_range(0, 99) < 3);
      rd = 5'($urandom_range(0, 31));
      a  = $urandom;
      b  = $urandom;
      wr = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 3);
      cycle(iv, rd, a, b, wr, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
